// File: rtl/imem_dmem_port_arbiter.sv
// Arbiter sharing one fixed-latency unified memory between fetch and load/store.
// Ports: clk/reset, IF read port, LS read/write port, single memory request port.
module imem_dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  // fetch side
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                stall_fetch_o,
  // load/store side
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  // memory side
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // owner encoding in the tag pipe
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  logic [CNT_W-1:0]   r_starve;
  logic [MEM_LAT-1:0] r_tag_vld;
  logic [MEM_LAT-1:0] r_tag_own;

  logic               w_if_force;
  logic               w_if_gnt;
  logic               w_ls_gnt;
  logic               w_ins_vld;
  logic               w_ins_own;
  logic [MEM_LAT-1:0] w_keep;
  logic               w_tail_vld;
  logic               w_tail_own;

  // ---------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------
  assign w_if_force = (r_starve == STARVE_LIM);

  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (!reset) begin
      if (if_req_i && (w_if_force || !ls_req_i)) begin
        w_if_gnt = 1'b1;
      end else if (ls_req_i) begin
        w_ls_gnt = 1'b1;
      end
    end
  end

  assign if_gnt_o      = w_if_gnt;
  assign ls_gnt_o      = w_ls_gnt;
  assign stall_fetch_o = if_req_i & ~w_if_gnt & ~reset;

  // ---------------------------------------------------------------
  // Memory request mux
  // ---------------------------------------------------------------
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_if_gnt) begin
      mem_req_o  = 1'b1;
      mem_be_o   = '1;
      mem_addr_o = if_addr_i;
    end else if (w_ls_gnt) begin
      mem_req_o  = 1'b1;
      mem_we_o   = ls_we_i;
      mem_be_o   = ls_we_i ? ls_be_i : {BE_W{1'b1}};
      mem_addr_o = ls_addr_i;
      mem_wdata_o = ls_we_i ? ls_wdata_i : '0;
    end
  end

  // ---------------------------------------------------------------
  // Starvation counter
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!if_req_i || w_if_gnt) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_LIM) begin
      r_starve <= r_starve + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------
  // Tag pipe: entry 0 is the newest, entry MEM_LAT-1 is the tail
  // ---------------------------------------------------------------
  // stores occupy a slot but never produce a response
  assign w_ins_vld = w_if_gnt | (w_ls_gnt & ~ls_we_i);
  assign w_ins_own = w_ls_gnt ? OWN_LS : OWN_IF;

  // a redirect kills every fetch still in flight, tail included
  always_comb begin
    w_keep = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      w_keep[i] = r_tag_vld[i] & ~(if_flush_i & (r_tag_own[i] == OWN_IF));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_vld <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_vld[0] <= w_ins_vld;
      r_tag_own[0] <= w_ins_own;
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        r_tag_vld[i] <= w_keep[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  // ---------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------
  assign w_tail_vld = w_keep[MEM_LAT-1] & ~reset;
  assign w_tail_own = r_tag_own[MEM_LAT-1];

  always_comb begin
    if_rvalid_o = 1'b0;
    ls_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ls_rdata_o  = '0;
    if (w_tail_vld) begin
      if (w_tail_own == OWN_LS) begin
        ls_rvalid_o = 1'b1;
        ls_rdata_o  = mem_rdata_i;
      end else begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end
    end
  end

endmodule
